// File: rtl/bus_mem_slave.sv
// Memory-side bus target: decodes DEST==MY_ID headers and runs word-beat
// write/read bursts against a local synchronous memory; outputs are registered.
module bus_mem_slave #(
  parameter logic [2:0] MY_ID  = 3'd1,
  parameter int         RD_LAT = 1
) (
  input  logic        BUS_CLK,
  input  logic        RST,
  input  logic [31:0] D,
  input  logic [15:0] A,
  input  logic [2:0]  MASTER,
  input  logic [2:0]  DEST,
  input  logic [11:0] SIZE,
  input  logic        RW,
  output logic [31:0] D_OUT,
  output logic        D_OE,
  output logic        ACK_OUT,
  output logic [13:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ready,
  output logic        busy,
  output logic [2:0]  cur_master,
  output logic        abort
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_WR_ACK  = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_DATA = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [10:0] beats_q, beats_d;
  logic [1:0]  size_lo_q, size_lo_d;
  logic [2:0]  master_q, master_d;
  logic [1:0]  rd_cnt_q, rd_cnt_d;
  logic [31:0] d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        ack_q, ack_d;
  logic [13:0] mem_addr_q, mem_addr_d;
  logic [3:0]  be_q, be_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        rd_en_q, rd_en_d;
  logic        abort_q, abort_d;

  logic        hit;
  logic [10:0] beats_in;
  logic [3:0]  last_be;
  logic        unused_a;

  assign hit      = (DEST == MY_ID);
  assign beats_in = {1'b0, SIZE[11:2]} + {10'd0, |SIZE[1:0]};
  // Byte alignment is implied by the word address; low address bits carry no meaning here.
  assign unused_a = ^A[1:0];

  always_comb begin
    case (size_lo_q)
      2'd1:    last_be = 4'b0001;
      2'd2:    last_be = 4'b0011;
      2'd3:    last_be = 4'b0111;
      default: last_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    size_lo_d  = size_lo_q;
    master_d   = master_q;
    rd_cnt_d   = rd_cnt_q;
    d_out_d    = '0;
    d_oe_d     = 1'b0;
    ack_d      = 1'b0;
    mem_addr_d = mem_addr_q;
    be_d       = '0;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      S_IDLE: if (hit) begin
        addr_d    = A[15:2];
        master_d  = MASTER;
        size_lo_d = SIZE[1:0];
        beats_d   = beats_in;
        if (SIZE == 12'd0) begin
          ack_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = RW ? S_WR : S_RD_REQ;
        end
      end
      S_WR: if (!hit) begin
        abort_d = 1'b1;
        state_d = S_IDLE;
      end else if (mem_ready) begin
        wr_en_d    = 1'b1;
        ack_d      = 1'b1;
        wr_data_d  = D;
        mem_addr_d = addr_q;
        be_d       = (beats_q == 11'd1) ? last_be : 4'b1111;
        addr_d     = addr_q + 14'd1;
        beats_d    = beats_q - 11'd1;
        state_d    = S_WR_ACK;
      end
      S_WR_ACK: if (!hit) begin
        abort_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        state_d = (beats_q == 11'd0) ? S_DONE : S_WR;
      end
      S_RD_REQ: if (!hit) begin
        abort_d = 1'b1;
        state_d = S_IDLE;
      end else if (mem_ready) begin
        rd_en_d    = 1'b1;
        mem_addr_d = addr_q;
        addr_d     = addr_q + 14'd1;
        beats_d    = beats_q - 11'd1;
        rd_cnt_d   = 2'd0;
        state_d    = S_RD_DATA;
      end
      // Wait out the memory latency, then register the returned word onto the bus.
      S_RD_DATA: if (!hit) begin
        abort_d = 1'b1;
        state_d = S_IDLE;
      end else if (rd_cnt_q != RD_LAT[1:0]) begin
        rd_cnt_d = rd_cnt_q + 2'd1;
      end else begin
        d_out_d = mem_rd_data;
        d_oe_d  = 1'b1;
        ack_d   = 1'b1;
        state_d = (beats_q == 11'd0) ? S_DONE : S_RD_REQ;
      end
      S_DONE: if (!hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beats_q    <= '0;
      size_lo_q  <= '0;
      master_q   <= '0;
      rd_cnt_q   <= '0;
      d_out_q    <= '0;
      d_oe_q     <= 1'b0;
      ack_q      <= 1'b0;
      mem_addr_q <= '0;
      be_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      rd_en_q    <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      size_lo_q  <= size_lo_d;
      master_q   <= master_d;
      rd_cnt_q   <= rd_cnt_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      ack_q      <= ack_d;
      mem_addr_q <= mem_addr_d;
      be_q       <= be_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      rd_en_q    <= rd_en_d;
      abort_q    <= abort_d;
    end
  end

  assign D_OUT       = d_out_q;
  assign D_OE        = d_oe_q;
  assign ACK_OUT     = ack_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = be_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_data = wr_data_q;
  assign mem_rd_en   = rd_en_q;
  assign busy        = (state_q != S_IDLE);
  assign cur_master  = master_q;
  assign abort       = abort_q;

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
- Memory-side target port on the system bus, directly downstream of the bus masters (bus controller and others) and the arbitrator.
- Detects transactions whose DEST equals its ID and runs word-beat write and read bursts against a local synchronous memory.
- Returns ACK and read data through separate output/enable ports; the bus top level does the wired-OR/tristate merge.

Parameters:
- MY_ID, 3'd1, bus target ID this port answers to; DEST=3'd0 means bus idle.
- RD_LAT, 1, memory read latency in cycles; only 1 is supported.

Ports:
- BUS_CLK  in  1  bus clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- D  in  32  bus data, write beats
- A  in  16  bus byte start address
- MASTER  in  3  ID of requesting master
- DEST  in  3  target ID
- SIZE  in  12  transfer length in bytes
- RW  in  1  1=write to slave, 0=read from slave
- D_OUT  out  32  read data driven onto bus
- D_OE  out  1  D_OUT valid/enable
- ACK_OUT  out  1  beat acknowledge
- mem_addr  out  14  memory word address
- mem_be  out  4  byte enables for writes
- mem_wr_en  out  1  memory write strobe
- mem_wr_data  out  32  memory write data
- mem_rd_en  out  1  memory read strobe
- mem_rd_data  in  32  read data, valid 1 cycle after mem_rd_en
- mem_ready  in  1  memory can accept an access this cycle
- busy  out  1  transaction in progress (any state but IDLE)
- cur_master  out  3  latched MASTER of current transaction
- abort  out  1  one-cycle pulse on aborted transfer

Behaviour:
- Reset (RST low, async): state IDLE. All outputs 0, including D_OUT, D_OE, ACK_OUT, mem strobes, busy, cur_master and abort.
- States: IDLE, WR, WR_ACK, RD_REQ, RD_DATA, DONE.
- IDLE: on a cycle with DEST==MY_ID:
  - latch word address A[15:2] (A[1:0] ignored), MASTER, RW, SIZE;
  - beats = (SIZE+3)>>2, 11-bit counter, max 1024;
  - SIZE==0: pulse ACK_OUT one cycle (null transfer), go DONE;
  - otherwise go WR if RW=1, else RD_REQ.
- Other DEST values are ignored with no output activity.
- Word address increments by 1 per beat, modulo 2^14; 0x3FFF wraps to 0x0000.
- WR: sample D only when mem_ready=1. Next cycle:
  - mem_wr_en=1, mem_wr_data=sampled D, mem_addr=current word address, ACK_OUT=1; go WR_ACK.
  - mem_be=4'b1111, except the last beat, where SIZE[1:0]=1/2/3 gives 0001/0011/0111 and 0 gives 1111.
- WR_ACK: one cycle gap while the master advances D. Return to WR, or go DONE after the last beat. Minimum 2 cycles per beat.
- RD_REQ: when mem_ready=1, assert mem_rd_en with mem_addr for one cycle; go RD_DATA.
- RD_DATA: D_OUT=mem_rd_data, D_OE=1 and ACK_OUT=1 for exactly one cycle, registered. Then go RD_REQ, or DONE after the last beat.
- mem_ready=0 stalls in WR/RD_REQ indefinitely with no strobes and no ACK.
- All strobes and ACK_OUT are single-cycle pulses. D_OE=0 whenever not in a read data cycle.
- Abort: DEST!=MY_ID in any state except IDLE and DONE gives a one-cycle abort pulse and a return to IDLE.
  - No further memory strobes are issued.
  - A memory write already registered this cycle completes.
- DONE: hold busy=1 until DEST!=MY_ID, then go IDLE with no abort pulse. This prevents the same header from retriggering.
- cur_master holds its value until the next transaction start; it clears only on reset.

Test Plan:
- Write: DEST=1, RW=1, A=0x0010, SIZE=8, beats 0xAAAA0001 and 0xAAAA0002 -> mem_wr_en at addr 0x004 then 0x005, be=1111, two ACK pulses at least 2 cycles apart, then DONE, then IDLE after DEST=0.
- Partial write: SIZE=6, A=0xFFFC -> writes at 0x3FFF with be=1111, then 0x0000 with be=0011 (wrap).
- Read: RW=0, A=0x0100, SIZE=12, memory returns 0x11/0x22/0x33 -> three single-cycle D_OE+ACK_OUT pulses carrying those values, at mem_addr 0x040..0x042.
- Stall and ignore: hold mem_ready=0 for 5 cycles mid-write -> no ACK and no strobes until ready=1. DEST=2 traffic -> zero activity.
- Abort and reset: DEST drops to 0 after 1 beat of SIZE=16 -> abort pulse, IDLE, no further writes. Repeat the transfer and pull RST low mid-read -> all outputs 0 immediately.
- SIZE=0 -> exactly one ACK pulse, no memory access, cur_master latched.
